// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_pkg
//  Description : Shared definitions for the sample-rate DSP chain (average
//                filter, sample stream FIFO).
//                - DSP_DATA_WIDTH : common sample width
//                - sample_t       : signed two's complement sample type
//                - level_width()  : width of an occupancy counter 0..depth
//  Revision    : 1.0 - initial release
// ============================================================================
package dsp_pkg;

  localparam int DSP_DATA_WIDTH = 8;

  typedef logic signed [DSP_DATA_WIDTH-1:0] sample_t;

  // A counter that must represent every value from 0 up to and including
  // depth needs one more bit than an index into depth entries.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : sample_fifo_mem
//  Description : Simple dual-port register array used as FIFO storage.
//                One synchronous write port, one asynchronous read port.
//                Contents are not reset.
//  Ports       : clk      - write clock
//                wr_en    - write strobe
//                wr_addr  - write address
//                wr_data  - write data
//                rd_addr  - read address
//                rd_data  - read data (combinational from rd_addr)
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/sample_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sample_stream_fifo
//  Description : Captures strobe-qualified samples from the DSP chain into a
//                small FIFO and presents them on a valid/ready interface with
//                a registered first-word-fall-through head. Samples arriving
//                while full with no simultaneous pop are dropped and flagged
//                on a sticky overflow bit.
//  Ports       : clk              - system clock, rising edge
//                reset            - asynchronous active-high reset
//                i_ce             - sample strobe, data_in valid when high
//                data_in          - signed input sample
//                o_valid          - data_out holds the FIFO head
//                i_ready          - consumer accepts head when o_valid high
//                data_out         - registered FIFO head
//                o_level          - stored entry count, 0..DEPTH
//                o_full           - o_level == DEPTH
//                o_overflow       - sticky, set when a sample is dropped
//                i_clear_overflow - synchronous clear of o_overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_stream_fifo
  import dsp_pkg::*;
#(
  parameter int    DATA_WIDTH  = DSP_DATA_WIDTH,
  parameter int    DEPTH       = 8,
  localparam int   LEVEL_WIDTH = level_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_ce,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic [LEVEL_WIDTH-1:0] o_level,
  output logic                   o_full,
  output logic                   o_overflow,
  input  logic                   i_clear_overflow
);

  localparam int                     PTR_WIDTH   = $clog2(DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_FULL  = LEVEL_WIDTH'(DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_ONE   = LEVEL_WIDTH'(1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_EMPTY = '0;
  localparam logic [PTR_WIDTH-1:0]   PTR_ONE     = PTR_WIDTH'(1);

  logic [PTR_WIDTH-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [LEVEL_WIDTH-1:0] level_q,    level_d;
  logic                   valid_q,    valid_d;
  logic                   full_q,     full_d;
  logic                   overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]  head_q,     head_d;

  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [PTR_WIDTH-1:0]   w_next_rd_addr;
  logic [DATA_WIDTH-1:0]  w_next_rd_data;

  // The memory holds every stored entry, including the one mirrored in the
  // head register. Reading rd_ptr+1 yields the entry behind the head, which
  // becomes the new head on a pop.
  assign w_next_rd_addr = rd_ptr_q + PTR_ONE;

  sample_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_push),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (w_next_rd_addr),
    .rd_data (w_next_rd_data)
  );

  always_comb begin
    w_pop  = valid_q & i_ready;
    // A full FIFO still accepts a sample when the head leaves on the same edge.
    w_push = i_ce & ((level_q != LEVEL_FULL) | w_pop);
    w_drop = i_ce & ~w_push;

    wr_ptr_d = w_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = w_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    level_d = level_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase

    valid_d = (level_d != LEVEL_EMPTY);
    full_d  = (level_d == LEVEL_FULL);

    // A new drop takes priority over a clear on the same edge.
    overflow_d = overflow_q;
    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (i_clear_overflow) begin
      overflow_d = 1'b0;
    end

    // Head update. With more than one entry stored, the successor is already
    // in memory; with exactly one, the successor can only be the sample being
    // pushed on this edge. When the FIFO goes empty the head holds its value.
    head_d = head_q;
    if (w_pop) begin
      if (level_q > LEVEL_ONE) begin
        head_d = w_next_rd_data;
      end else if (w_push) begin
        head_d = data_in;
      end
    end else if ((level_q == LEVEL_EMPTY) && w_push) begin
      head_d = data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      valid_q    <= valid_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      head_q     <= head_d;
    end
  end

  assign o_valid    = valid_q;
  assign data_out   = head_q;
  assign o_level    = level_q;
  assign o_full     = full_q;
  assign o_overflow = overflow_q;

endmodule
`default_nettype wire
